stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 134 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: IDLE/RUN/PAUSE/LAP sequencing of a 4-digit BCD
// centisecond counter (SS.CC) with an optional frozen lap display.
// Optional feature macro: STOPWATCH_LAP_EN (adds the LAP state and the lap register).
//
// state | meaning
// ------+-------------------------------------------------------------
// idle  | stopped, count cleared to 00.00, waiting for start
// run   | counting on tick, display shows live count
// pause | stopped, count held, start resumes / lap_reset clears
// lap   | counting on tick, display frozen on captured lap value
module stopwatch_ctrl #(
  parameter int WRAP_SEC = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        start_stop,
  input  logic        lap_reset,
  output logic [15:0] bcd,
  output logic        running,
  output logic        lap_frozen,
  output logic        wrap
);

`ifdef STOPWATCH_LAP_EN
  typedef enum logic [1:0] {st_idle = 2'd0, st_run = 2'd1, st_pause = 2'd2, st_lap = 2'd3} state_t;
`else
  typedef enum logic [1:0] {st_idle = 2'd0, st_run = 2'd1, st_pause = 2'd2} state_t;
`endif

  localparam logic [3:0] sec_tens_max = 4'((WRAP_SEC - 1) / 10);
  localparam logic [3:0] sec_ones_max = 4'((WRAP_SEC - 1) % 10);
  localparam logic [15:0] cnt_max = {sec_tens_max, sec_ones_max, 4'd9, 4'd9};

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_inc;
  logic        clr, cap, count_en, at_max;
  logic        c0, c1, c2;

  assign at_max   = (cnt == cnt_max);
`ifdef STOPWATCH_LAP_EN
  assign count_en = tick && ((state == st_run) || (state == st_lap));
`else
  assign count_en = tick && (state == st_run);
`endif

  // BCD increment with digit carries; the terminal count reloads to 00.00
  always_comb begin
    cnt_inc = cnt;
    c0 = (cnt[3:0] == 4'd9);
    c1 = c0 && (cnt[7:4] == 4'd9);
    c2 = c1 && (cnt[11:8] == 4'd9);
    if (at_max) begin
      cnt_inc = 16'h0000;
    end else begin
      cnt_inc[3:0] = c0 ? 4'd0 : cnt[3:0] + 4'd1;
      if (c0) cnt_inc[7:4]   = (cnt[7:4] == 4'd9) ? 4'd0 : cnt[7:4] + 4'd1;
      if (c1) cnt_inc[11:8]  = (cnt[11:8] == 4'd9) ? 4'd0 : cnt[11:8] + 4'd1;
      if (c2) cnt_inc[15:12] = cnt[15:12] + 4'd1;
    end
  end

  // Next-state decode; start_stop wins over lap_reset when both arrive together
  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    cap       = 1'b0;
    case (state)
      st_idle: begin
        if (start_stop) state_nxt = st_run;
      end
      st_run: begin
        if (start_stop) state_nxt = st_pause;
`ifdef STOPWATCH_LAP_EN
        else if (lap_reset) begin
          state_nxt = st_lap;
          cap       = 1'b1;
        end
`endif
      end
`ifdef STOPWATCH_LAP_EN
      st_lap: begin
        if (start_stop)     state_nxt = st_pause;
        else if (lap_reset) state_nxt = st_run;
      end
`endif
      st_pause: begin
        if (start_stop) state_nxt = st_run;
        else if (lap_reset) begin
          state_nxt = st_idle;
          clr       = 1'b1;
        end
      end
      default: state_nxt = st_idle;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= st_idle;
    else        state <= state_nxt;
  end

  // Live count and wrap pulse; clear only happens from pause so it never meets a counting tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= 16'h0000;
      wrap <= 1'b0;
    end else begin
      wrap <= count_en && at_max;
      if (clr)           cnt <= 16'h0000;
      else if (count_en) cnt <= cnt_inc;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [15:0] lap_q;

  // Lap register captures the pre-edge count on entry to lap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   lap_q <= 16'h0000;
    else if (cap) lap_q <= cnt;
  end

  assign bcd        = (state == st_lap) ? lap_q : cnt;
  assign lap_frozen = (state == st_lap);
  assign running    = (state == st_run) || (state == st_lap);
`else
  assign bcd        = cnt;
  assign lap_frozen = 1'b0;
  assign running    = (state == st_run);
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl (WRAP_SEC=60); LAP checks follow STOPWATCH_LAP_EN.
module tb_stopwatch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        start_stop = 1'b0;
  logic        lap_reset = 1'b0;
  logic [15:0] bcd;
  logic        running, lap_frozen, wrap;

  int tests = 0;
  int fails = 0;

  stopwatch_ctrl #(.WRAP_SEC(60)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start_stop(start_stop),
    .lap_reset(lap_reset), .bcd(bcd), .running(running),
    .lap_frozen(lap_frozen), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
    end
  endtask

  task automatic pulse(input logic ss, input logic lr, input logic tk);
    @(negedge clk);
    start_stop = ss; lap_reset = lr; tick = tk;
    @(negedge clk);
    start_stop = 1'b0; lap_reset = 1'b0; tick = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_bcd", bcd, 16'h0000);
    chk("rst_running", 16'(running), 16'h0);
    chk("rst_lap_frozen", 16'(lap_frozen), 16'h0);
    chk("rst_wrap", 16'(wrap), 16'h0);
    @(negedge clk) rst_n = 1'b1;

    // idle ignores ticks and lap_reset
    tick_n(3);
    pulse(1'b0, 1'b1, 1'b0);
    chk("idle_bcd", bcd, 16'h0000);
    chk("idle_running", 16'(running), 16'h0);

    // start then 123 ticks
    pulse(1'b1, 1'b0, 1'b0);
    chk("start_running", 16'(running), 16'h1);
    tick_n(123);
    chk("run123_bcd", bcd, 16'h0123);
    chk("run123_running", 16'(running), 16'h1);
    chk("run123_wrap", 16'(wrap), 16'h0);

    // simultaneous buttons in run: start_stop wins -> pause, count held
    pulse(1'b1, 1'b1, 1'b0);
    chk("both_running", 16'(running), 16'h0);
    chk("both_lap_frozen", 16'(lap_frozen), 16'h0);
    chk("both_bcd", bcd, 16'h0123);
    tick_n(5);
    chk("pause_hold_bcd", bcd, 16'h0123);

    // lap_reset in pause clears to idle
    pulse(1'b0, 1'b1, 1'b0);
    chk("clr_bcd", bcd, 16'h0000);
    chk("clr_running", 16'(running), 16'h0);

    // run to 12.34, pause, then lap_reset together with tick
    pulse(1'b1, 1'b0, 1'b0);
    tick_n(1234);
    chk("run1234_bcd", bcd, 16'h1234);
    pulse(1'b1, 1'b0, 1'b0);
    chk("pause1234_running", 16'(running), 16'h0);
    chk("pause1234_bcd", bcd, 16'h1234);
    pulse(1'b0, 1'b1, 1'b1);
    chk("clr_tick_bcd", bcd, 16'h0000);
    chk("clr_tick_running", 16'(running), 16'h0);
    pulse(1'b1, 1'b0, 1'b0);
    chk("restart_running", 16'(running), 16'h1);
    chk("restart_bcd", bcd, 16'h0000);

    // wrap at 59.99
    tick_n(5999);
    chk("pre_wrap_bcd", bcd, 16'h5999);
    chk("pre_wrap_wrap", 16'(wrap), 16'h0);
    pulse(1'b0, 1'b0, 1'b1);
    chk("wrap_bcd", bcd, 16'h0000);
    chk("wrap_pulse", 16'(wrap), 16'h1);
    @(negedge clk);
    chk("wrap_one_cycle", 16'(wrap), 16'h0);

    // tick on the edge leaving run still counts
    pulse(1'b1, 1'b0, 1'b1);
    chk("exit_tick_bcd", bcd, 16'h0001);
    chk("exit_tick_running", 16'(running), 16'h0);
    pulse(1'b0, 1'b1, 1'b0);
    chk("clr2_bcd", bcd, 16'h0000);
    pulse(1'b1, 1'b0, 1'b0);
    tick_n(500);
    chk("run500_bcd", bcd, 16'h0500);

`ifdef STOPWATCH_LAP_EN
    pulse(1'b0, 1'b1, 1'b0);
    chk("lap_enter_frozen", 16'(lap_frozen), 16'h1);
    tick_n(50);
    chk("lap_bcd", bcd, 16'h0500);
    chk("lap_frozen", 16'(lap_frozen), 16'h1);
    chk("lap_running", 16'(running), 16'h1);
    pulse(1'b0, 1'b1, 1'b0);
    chk("lap_exit_bcd", bcd, 16'h0550);
    chk("lap_exit_frozen", 16'(lap_frozen), 16'h0);
`else
    pulse(1'b0, 1'b1, 1'b0);
    chk("nolap_running", 16'(running), 16'h1);
    chk("nolap_frozen", 16'(lap_frozen), 16'h0);
    tick_n(50);
    chk("nolap_bcd", bcd, 16'h0550);
`endif

    // async reset mid-run, checked before the next clk edge
    tick_n(7);
    chk("prerst_bcd", bcd, 16'h0557);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bcd", bcd, 16'h0000);
    chk("arst_running", 16'(running), 16'h0);
    chk("arst_lap_frozen", 16'(lap_frozen), 16'h0);
    chk("arst_wrap", 16'(wrap), 16'h0);
    @(negedge clk) rst_n = 1'b1;
    tick_n(2);
    chk("post_rst_bcd", bcd, 16'h0000);
    chk("post_rst_running", 16'(running), 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
